fib_seq_engine: RTL and testbench
=================================

Name: fib_seq_engine

Overview:
Synthesizable iterative Fibonacci generator. It is the hardware stage that replaces the software fibonacci() model in the DPI fibonacci testbench. It accepts an index n over a valid/ready request channel, iterates one addition per clock, and returns F(n) over a valid/ready response channel. The existing checker consumes the response and compares it against the golden vectors in fibonacci.dat.

Parameters:
- WIDTH, 32: result width in bits.
- N_WIDTH, 8: index width in bits.
- MAX_N, 47: largest index whose F(n) fits in WIDTH bits unsigned. Must be 47 when WIDTH=32.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request n is valid.
- req_ready  out  1  engine can accept a request.
- req_n  in  N_WIDTH  Fibonacci index.
- rsp_valid  out  1  result is valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_y  out  WIDTH  F(n); 0 on overflow.
- rsp_ovf  out  1  n > MAX_N; result not representable.
- busy  out  1  state != IDLE.
- rsp_count  out  32  number of completed response handshakes.

Behaviour:
- Convention: F(0)=0, F(1)=1, F(2)=1, F(n)=F(n-1)+F(n-2).
- Reset (async assert, sync release): state=IDLE, rsp_valid=0, rsp_y=0, rsp_ovf=0, rsp_count=0, internal a/b/cnt=0. req_ready=1 and busy=0 once reset is released.
- Reset mid-operation: the computation is abandoned, the response is discarded, and no partial result is ever presented.
- FSM states: IDLE, CALC, DONE.
- req_ready=1 only in IDLE. Accept occurs when req_valid && req_ready at a rising edge.
- IDLE, on accept (decided in this priority order):
  - n > MAX_N: go to DONE with rsp_y=0, rsp_ovf=1.
  - n=0: go to DONE with rsp_y=0, rsp_ovf=0.
  - n=1: go to DONE with rsp_y=1, rsp_ovf=0.
  - n≥2: a=0, b=1, cnt=n; go to CALC.
- CALC, every edge:
  - If cnt==2: rsp_y<=a+b, go to DONE.
  - Else: a<=b, b<=a+b, cnt<=cnt-1.
- Latency, counted from the accept edge to the edge at which rsp_valid rises:
  - n=0, n=1, or overflow: 1 cycle.
  - 2 ≤ n ≤ MAX_N: n cycles (F(47) takes 47 cycles).
- DONE:
  - rsp_valid=1.
  - rsp_y and rsp_ovf are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE, rsp_valid<=0, rsp_count<=rsp_count+1.
- No overlap: a new request cannot be accepted in the same cycle as the response handshake. The minimum request-to-request spacing is latency+1 cycles.
- Arithmetic: the a+b adder is WIDTH bits, unsigned, with no carry-out. The MAX_N bound guarantees no internal overflow.
- rsp_count wraps modulo 2^32.
- In IDLE or CALC, rsp_valid=0. rsp_y keeps its last value and is don't-care while rsp_valid=0.
- req_n is sampled only at the accept edge. Later changes to req_n do not affect an in-flight computation.

Decomposition:
- Package fib_pkg holds:
  - the state enum typedef fib_state_e {IDLE, CALC, DONE};
  - the constants FIB_WIDTH=32, FIB_N_WIDTH=8, FIB_MAX_N=47;
  - the localparam table of golden values for F(1), F(10), F(46), F(47), for bench use.
- The block is a single module with no sub-module; the datapath (a/b/cnt) and the FSM are small enough to share one module.

Test Plan:
- Simple cases: reset, then n=1 with rsp_ready=1. Requires rsp_valid 1 cycle after accept, rsp_y=1, rsp_ovf=0, rsp_count=1. Then n=0 returns rsp_y=0 with latency 1.
- Sweep: n=1..46 back to back, rsp_ready held at 1. Every rsp_y must match fibonacci.dat (e.g. n=10→55, n=46→1836311903), with 0 mismatches and rsp_count=46.
- Upper boundaries:
  - n=47 → rsp_y=2971215073, latency 47, rsp_ovf=0.
  - n=48 → rsp_y=0, rsp_ovf=1, latency 1.
  - n=255 → same result as n=48.
- Backpressure: n=20 with rsp_ready=0 for 10 cycles after rsp_valid rises. Requires rsp_y=6765 held stable, req_ready=0 throughout, and rsp_count incremented only on the handshake cycle.
- Reset mid-operation: n=40, assert reset_n=0 at cycle 15 of CALC. Requires rsp_valid=0, rsp_count=0, req_ready=1 immediately after release. A following n=5 must return 5 with latency 5.
- Input stability: change req_n and pulse req_valid during CALC of n=12. Requires no extra accept and rsp_y=144.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the iterative Fibonacci engine.
// The golden table gives a few known F(n) values for anyone checking the engine.
package fib_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} fib_state_e;

  localparam int FIB_WIDTH   = 32;
  localparam int FIB_N_WIDTH = 8;
  localparam int FIB_MAX_N   = 47;

  localparam int          FIB_GOLDEN_N [4] = '{1, 10, 46, 47};
  localparam logic [31:0] FIB_GOLDEN_Y [4] = '{32'd1, 32'd55, 32'd1836311903, 32'd2971215073};

endpackage

// File: rtl/fib_seq_engine.sv
// Iterative Fibonacci generator: takes n over a valid/ready request channel, performs
// one addition per clock and returns F(n) over a valid/ready response channel.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int WIDTH   = FIB_WIDTH,
  parameter int N_WIDTH = FIB_N_WIDTH,
  parameter int MAX_N   = FIB_MAX_N
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [N_WIDTH-1:0] req_n,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_y,
  output logic               rsp_ovf,
  output logic               busy,
  output logic [31:0]        rsp_count
);

  fib_state_e         state;
  fib_state_e         state_next;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   sum;
  logic [N_WIDTH-1:0] cnt;
  logic               accept;
  logic               short_req;

  assign sum       = a + b;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  // Overflow and n<2 bypass the adder loop and answer in a single cycle.
  assign short_req = (req_n > N_WIDTH'(MAX_N)) || (req_n < N_WIDTH'(2));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = short_req ? DONE : CALC;
      CALC:    if (cnt == N_WIDTH'(2)) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Invariant in CALC: after k steps a=F(k), b=F(k+1), cnt=n-k; so a+b at cnt==2 is F(n).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a         <= '0;
      b         <= '0;
      cnt       <= '0;
      rsp_y     <= '0;
      rsp_ovf   <= 1'b0;
      rsp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_n > N_WIDTH'(MAX_N)) begin
              rsp_y   <= '0;
              rsp_ovf <= 1'b1;
            end else if (req_n == '0) begin
              rsp_y   <= '0;
              rsp_ovf <= 1'b0;
            end else if (req_n == N_WIDTH'(1)) begin
              rsp_y   <= WIDTH'(1);
              rsp_ovf <= 1'b0;
            end else begin
              a       <= '0;
              b       <= WIDTH'(1);
              cnt     <= req_n;
              rsp_ovf <= 1'b0;
            end
          end
        end
        CALC: begin
          if (cnt == N_WIDTH'(2)) begin
            rsp_y <= sum;
          end else begin
            a   <= b;
            b   <= sum;
            cnt <= cnt - N_WIDTH'(1);
          end
        end
        DONE: begin
          if (rsp_ready) rsp_count <= rsp_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Self-checking bench for fib_seq_engine: directed boundary scenarios plus random indices,
// compared against a Fibonacci table built with plain arithmetic.
module tb_fib_seq_engine;
  import fib_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_n = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_y;
  logic        rsp_ovf;
  logic        busy;
  logic [31:0] rsp_count;

  int compared = 0;
  int mismatched = 0;
  int exp_count = 0;
  longint unsigned fib_tab [0:FIB_MAX_N];

  always #5 clock = ~clock;

  fib_seq_engine dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf),
    .busy(busy), .rsp_count(rsp_count)
  );

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint unsigned ref_y(int n);
    return (n > FIB_MAX_N) ? 64'd0 : fib_tab[n];
  endfunction

  function automatic int ref_lat(int n);
    return (n < 2 || n > FIB_MAX_N) ? 1 : n;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_count = 0;
    @(negedge clock);
  endtask

  // Drives one request with rsp_ready held high; reports latency and captured result.
  task automatic run_req(input int n, output int lat, output logic [31:0] y,
                         output logic ovf, output bit ok);
    int w;
    ok = 1'b1; lat = 0; y = '0; ovf = 1'b0;
    @(negedge clock);
    req_n = n[7:0]; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin @(negedge clock); w++; end
    if (!req_ready) begin ok = 1'b0; req_valid = 1'b0; return; end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; req_n = 8'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clock); lat++; end
    if (!rsp_valid) begin ok = 1'b0; return; end
    y = rsp_y; ovf = rsp_ovf;
    @(negedge clock);
    exp_count++;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    compared++; if (rsp_y !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_rsp_y: got %0d expected 0", rsp_y); end
    compared++; if (rsp_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_ovf: got %0b expected 0", rsp_ovf); end
    compared++; if (rsp_count !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_rsp_count: got %0d expected 0", rsp_count); end
    @(negedge clock);
    reset_n = 1'b1;
    exp_count = 0;
    #1;
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_req_ready: got %0b expected 1", req_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_simple();
    int lat; logic [31:0] y; logic ovf; bit ok;
    run_req(1, lat, y, ovf, ok);
    compared++; if (!ok) begin mismatched++; $display("[TB] FAIL simple_n1_timeout: got no response expected one"); end
    compared++; if (lat !== 1) begin mismatched++; $display("[TB] FAIL simple_n1_latency: got %0d expected 1", lat); end
    compared++; if (y !== 32'd1) begin mismatched++; $display("[TB] FAIL simple_n1_y: got %0d expected 1", y); end
    compared++; if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL simple_n1_ovf: got %0b expected 0", ovf); end
    compared++; if (rsp_count !== 32'd1) begin mismatched++; $display("[TB] FAIL simple_count: got %0d expected 1", rsp_count); end
    run_req(0, lat, y, ovf, ok);
    compared++; if (!ok) begin mismatched++; $display("[TB] FAIL simple_n0_timeout: got no response expected one"); end
    compared++; if (lat !== 1) begin mismatched++; $display("[TB] FAIL simple_n0_latency: got %0d expected 1", lat); end
    compared++; if (y !== 32'd0) begin mismatched++; $display("[TB] FAIL simple_n0_y: got %0d expected 0", y); end
  endtask

  task automatic test_sweep();
    int lat; logic [31:0] y; logic ovf; bit ok;
    do_reset();
    for (int n = 1; n <= 46; n++) begin
      run_req(n, lat, y, ovf, ok);
      compared++; if (!ok) begin mismatched++; $display("[TB] FAIL sweep_timeout n=%0d: got no response expected one", n); end
      compared++; if (y !== ref_y(n)) begin mismatched++; $display("[TB] FAIL sweep_y n=%0d: got %0d expected %0d", n, y, ref_y(n)); end
      compared++; if (lat !== ref_lat(n)) begin mismatched++; $display("[TB] FAIL sweep_latency n=%0d: got %0d expected %0d", n, lat, ref_lat(n)); end
      for (int g = 0; g < 4; g++) begin
        if (FIB_GOLDEN_N[g] == n) begin
          compared++; if (y !== FIB_GOLDEN_Y[g]) begin mismatched++; $display("[TB] FAIL sweep_golden n=%0d: got %0d expected %0d", n, y, FIB_GOLDEN_Y[g]); end
        end
      end
    end
    compared++; if (rsp_count !== 32'd46) begin mismatched++; $display("[TB] FAIL sweep_count: got %0d expected 46", rsp_count); end
  endtask

  task automatic test_upper();
    int lat; logic [31:0] y; logic ovf; bit ok;
    int ns [3] = '{47, 48, 255};
    for (int i = 0; i < 3; i++) begin
      run_req(ns[i], lat, y, ovf, ok);
      compared++; if (!ok) begin mismatched++; $display("[TB] FAIL upper_timeout n=%0d: got no response expected one", ns[i]); end
      compared++; if (y !== ref_y(ns[i])) begin mismatched++; $display("[TB] FAIL upper_y n=%0d: got %0d expected %0d", ns[i], y, ref_y(ns[i])); end
      compared++; if (ovf !== (ns[i] > FIB_MAX_N)) begin mismatched++; $display("[TB] FAIL upper_ovf n=%0d: got %0b expected %0b", ns[i], ovf, ns[i] > FIB_MAX_N); end
      compared++; if (lat !== ref_lat(ns[i])) begin mismatched++; $display("[TB] FAIL upper_latency n=%0d: got %0d expected %0d", ns[i], lat, ref_lat(ns[i])); end
    end
    compared++; if (32'(fib_tab[47]) !== 32'd2971215073 || y !== 32'd0) begin mismatched++; $display("[TB] FAIL upper_n255_y: got %0d expected 0", y); end
  endtask

  task automatic test_backpressure();
    int lat; bit bad;
    @(negedge clock);
    rsp_ready = 1'b0; req_n = 8'd20; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clock); lat++; end
    compared++; if (lat !== 20) begin mismatched++; $display("[TB] FAIL bp_latency: got %0d expected 20", lat); end
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_y !== 32'd6765 || req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_count !== 32'(exp_count)) begin
        bad = 1'b1;
        $display("[TB] FAIL bp_hold cycle %0d: got y=%0d ready=%0b valid=%0b count=%0d expected y=6765 ready=0 valid=1 count=%0d",
                 c, rsp_y, req_ready, rsp_valid, rsp_count, exp_count);
      end
      if (c < 9) @(negedge clock);
    end
    compared++; if (bad) mismatched++;
    rsp_ready = 1'b1;
    @(negedge clock);
    exp_count++;
    compared++; if (rsp_count !== 32'(exp_count)) begin mismatched++; $display("[TB] FAIL bp_count: got %0d expected %0d", rsp_count, exp_count); end
    compared++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release: got valid=%0b ready=%0b expected valid=0 ready=1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] y; logic ovf; bit ok, bad;
    do_reset();
    @(negedge clock);
    req_n = 8'd40; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (15) @(negedge clock);
    compared++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_in_calc: got busy=%0b valid=%0b expected busy=1 valid=0", busy, rsp_valid); end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    exp_count = 0;
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_valid: got %0b expected 0", rsp_valid); end
    compared++; if (rsp_count !== 32'd0) begin mismatched++; $display("[TB] FAIL mid_count: got %0d expected 0", rsp_count); end
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_ready: got %0b expected 1", req_ready); end
    bad = 1'b0;
    repeat (40) begin @(negedge clock); if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1; end
    compared++; if (bad) begin mismatched++; $display("[TB] FAIL mid_no_partial: got a response or busy after reset expected idle"); end
    run_req(5, lat, y, ovf, ok);
    compared++; if (!ok || y !== 32'd5) begin mismatched++; $display("[TB] FAIL mid_after_y: got %0d expected 5", y); end
    compared++; if (lat !== 5) begin mismatched++; $display("[TB] FAIL mid_after_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_input_stability();
    int lat; bit bad;
    @(negedge clock);
    rsp_ready = 1'b1; req_n = 8'd12; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      req_valid = (lat < 8) ? 1'($urandom) : 1'b0;
      req_n = 8'($urandom);
      @(negedge clock);
      lat++;
    end
    req_valid = 1'b0;
    compared++; if (lat !== 12) begin mismatched++; $display("[TB] FAIL stab_latency: got %0d expected 12", lat); end
    compared++; if (rsp_y !== 32'd144) begin mismatched++; $display("[TB] FAIL stab_y: got %0d expected 144", rsp_y); end
    @(negedge clock);
    exp_count++;
    bad = 1'b0;
    repeat (3) begin if (busy !== 1'b0) bad = 1'b1; @(negedge clock); end
    compared++; if (bad) begin mismatched++; $display("[TB] FAIL stab_extra_accept: got busy=1 expected busy=0"); end
    compared++; if (rsp_count !== 32'(exp_count)) begin mismatched++; $display("[TB] FAIL stab_count: got %0d expected %0d", rsp_count, exp_count); end
  endtask

  task automatic test_random();
    int lat, n; logic [31:0] y; logic ovf; bit ok;
    for (int i = 0; i < 24; i++) begin
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(48, 255)) : int'($urandom_range(0, 47));
      run_req(n, lat, y, ovf, ok);
      compared++;
      if (!ok || y !== ref_y(n) || ovf !== (n > FIB_MAX_N) || lat !== ref_lat(n)) begin
        mismatched++;
        $display("[TB] FAIL random n=%0d: got y=%0d ovf=%0b lat=%0d ok=%0b expected y=%0d ovf=%0b lat=%0d",
                 n, y, ovf, lat, ok, ref_y(n), n > FIB_MAX_N, ref_lat(n));
      end
    end
    compared++; if (rsp_count !== 32'(exp_count)) begin mismatched++; $display("[TB] FAIL random_count: got %0d expected %0d", rsp_count, exp_count); end
  endtask

  initial begin
    fib_tab[0] = 0;
    fib_tab[1] = 1;
    for (int i = 2; i <= FIB_MAX_N; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];
    test_reset();
    test_simple();
    test_sweep();
    test_upper();
    test_backpressure();
    test_reset_mid();
    test_input_stability();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
